// File: rtl/rdma_tx_meta_arbiter_if.sv
// Requester-side and encapsulator-side bundles for rdma_tx_meta_arbiter.
// Requester i occupies slice i of every flattened bus.

interface rdma_tx_req_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned META_W  = 128
);
  logic [NUM_REQ*META_W-1:0] s_meta_data;
  logic [NUM_REQ-1:0]        s_meta_valid;
  logic [NUM_REQ-1:0]        s_meta_ready;
  logic [NUM_REQ*32-1:0]     s_pay_tdata;
  logic [NUM_REQ*4-1:0]      s_pay_tkeep;
  logic [NUM_REQ-1:0]        s_pay_tvalid;
  logic [NUM_REQ-1:0]        s_pay_tready;
  logic [NUM_REQ-1:0]        s_pay_tlast;
  logic [NUM_REQ-1:0]        s_pay_tuser;

  modport master (
    output s_meta_data, s_meta_valid, s_pay_tdata, s_pay_tkeep,
           s_pay_tvalid, s_pay_tlast, s_pay_tuser,
    input  s_meta_ready, s_pay_tready
  );

  modport slave (
    input  s_meta_data, s_meta_valid, s_pay_tdata, s_pay_tkeep,
           s_pay_tvalid, s_pay_tlast, s_pay_tuser,
    output s_meta_ready, s_pay_tready
  );
endinterface

interface rdma_tx_encap_if;
  logic [15:0] m_meta_payload_len;
  logic [31:0] m_meta_src_ip;
  logic [31:0] m_meta_dst_ip;
  logic [15:0] m_meta_src_port;
  logic [15:0] m_meta_dst_port;
  logic [7:0]  m_meta_flags;
  logic [7:0]  m_meta_endpoint_id;
  logic        m_meta_valid;
  logic        m_meta_ready;
  logic [31:0] m_pay_tdata;
  logic [3:0]  m_pay_tkeep;
  logic        m_pay_tvalid;
  logic        m_pay_tready;
  logic        m_pay_tlast;
  logic        m_pay_tuser;

  modport master (
    output m_meta_payload_len, m_meta_src_ip, m_meta_dst_ip, m_meta_src_port,
           m_meta_dst_port, m_meta_flags, m_meta_endpoint_id, m_meta_valid,
           m_pay_tdata, m_pay_tkeep, m_pay_tvalid, m_pay_tlast, m_pay_tuser,
    input  m_meta_ready, m_pay_tready
  );

  modport slave (
    input  m_meta_payload_len, m_meta_src_ip, m_meta_dst_ip, m_meta_src_port,
           m_meta_dst_port, m_meta_flags, m_meta_endpoint_id, m_meta_valid,
           m_pay_tdata, m_pay_tkeep, m_pay_tvalid, m_pay_tlast, m_pay_tuser,
    output m_meta_ready, m_pay_tready
  );
endinterface

// File: rtl/rdma_tx_meta_arbiter.sv
// Round-robin scheduler sharing one encapsulator among NUM_REQ transmit
// requesters: arbitrate on metadata, forward the winner's header, then
// pass its payload stream through until tlast.

module rdma_tx_meta_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned META_W  = 128
) (
  input  logic                iClk,
  input  logic                iRst_n,
  rdma_tx_req_if.slave        req,
  rdma_tx_encap_if.master     encap,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic                o_busy,
  output logic [31:0]         o_pkt_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, META, DATA} state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    last_q;
  logic [META_W-1:0]   meta_q;
  logic [31:0]         pkt_cnt_q;

  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [META_W-1:0]   pick_meta;

  // Round-robin pick: walk offsets from farthest to nearest so the nearest
  // requester after last_q is the final (winning) assignment.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_meta = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(last_q) + NUM_REQ - k) % NUM_REQ;
      if (req.s_meta_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(idx);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) pick_meta = req.s_meta_data[i*META_W +: META_W];
    end
  end

  // Route handshakes and payload of the granted requester only.
  always_comb begin
    req.s_meta_ready   = '0;
    req.s_pay_tready   = '0;
    encap.m_pay_tdata  = '0;
    encap.m_pay_tkeep  = '0;
    encap.m_pay_tvalid = 1'b0;
    encap.m_pay_tlast  = 1'b0;
    encap.m_pay_tuser  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        if (state_q == META) req.s_meta_ready[i] = encap.m_meta_ready;
        if (state_q == DATA) begin
          req.s_pay_tready[i] = encap.m_pay_tready;
          encap.m_pay_tdata   = req.s_pay_tdata[i*32 +: 32];
          encap.m_pay_tkeep   = req.s_pay_tkeep[i*4 +: 4];
          encap.m_pay_tvalid  = req.s_pay_tvalid[i];
          encap.m_pay_tlast   = req.s_pay_tlast[i];
          encap.m_pay_tuser   = req.s_pay_tuser[i];
        end
      end
    end
  end

  // Arbitration FSM: IDLE -> META (header handshake) -> DATA (until tlast).
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      meta_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gidx_q  <= pick_idx;
            meta_q  <= pick_meta;
            state_q <= META;
          end
        end
        META: begin
          if (encap.m_meta_ready) begin
            last_q  <= gidx_q;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (encap.m_pay_tvalid && encap.m_pay_tready && encap.m_pay_tlast) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            grant_q   <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign encap.m_meta_valid       = (state_q == META);
  assign encap.m_meta_payload_len = meta_q[META_W-1  -: 16];
  assign encap.m_meta_src_ip      = meta_q[META_W-17 -: 32];
  assign encap.m_meta_dst_ip      = meta_q[META_W-49 -: 32];
  assign encap.m_meta_src_port    = meta_q[META_W-81 -: 16];
  assign encap.m_meta_dst_port    = meta_q[META_W-97 -: 16];
  assign encap.m_meta_flags       = meta_q[15:8];
  assign encap.m_meta_endpoint_id = meta_q[7:0];

  assign o_grant     = grant_q;
  assign o_busy      = (state_q != IDLE);
  assign o_pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_rdma_tx_meta_arbiter.sv
// Randomized scoreboard bench for rdma_tx_meta_arbiter: requester drivers
// push expected packets, a negedge monitor predicts the round-robin winner
// and compares metadata and payload beats.

module tb_rdma_tx_meta_arbiter;

  localparam int NR   = 4;
  localparam int MW   = 128;
  localparam int NPKT = 8;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  rdma_tx_req_if #(.NUM_REQ(NR), .META_W(MW)) req_if ();
  rdma_tx_encap_if enc_if ();

  logic [NR-1:0] o_grant;
  logic          o_busy;
  logic [31:0]   o_pkt_count;

  rdma_tx_meta_arbiter #(.NUM_REQ(NR), .META_W(MW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .req(req_if), .encap(enc_if),
    .o_grant(o_grant), .o_busy(o_busy), .o_pkt_count(o_pkt_count)
  );

  // Per-requester drive state, packed onto the flattened buses.
  logic [MW-1:0] d_meta [NR];
  logic          d_mv   [NR];
  logic [31:0]   d_td   [NR];
  logic [3:0]    d_tk   [NR];
  logic          d_tv   [NR];
  logic          d_tl   [NR];
  logic          d_tu   [NR];

  always_comb begin
    req_if.s_meta_data  = '0;
    req_if.s_meta_valid = '0;
    req_if.s_pay_tdata  = '0;
    req_if.s_pay_tkeep  = '0;
    req_if.s_pay_tvalid = '0;
    req_if.s_pay_tlast  = '0;
    req_if.s_pay_tuser  = '0;
    for (int i = 0; i < NR; i++) begin
      req_if.s_meta_data[i*MW +: MW] = d_meta[i];
      req_if.s_meta_valid[i]         = d_mv[i];
      req_if.s_pay_tdata[i*32 +: 32] = d_td[i];
      req_if.s_pay_tkeep[i*4 +: 4]   = d_tk[i];
      req_if.s_pay_tvalid[i]         = d_tv[i];
      req_if.s_pay_tlast[i]          = d_tl[i];
      req_if.s_pay_tuser[i]          = d_tu[i];
    end
  end

  typedef struct packed {
    logic [127:0]     meta;
    logic [3:0]       nb;
    logic [7:0][37:0] beat;   // {data, keep, last, user}
  } pkt_t;

  pkt_t exp_q [NR][$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int o = 1; o <= NR; o++) begin
      if (v[(last + o) % NR]) return (last + o) % NR;
    end
    return -1;
  endfunction

  // Encapsulator sink: random readiness with occasional long metadata stalls.
  logic enc_rand = 1'b1;
  initial begin
    int stall;
    stall = 0;
    enc_if.m_meta_ready = 1'b0;
    enc_if.m_pay_tready = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      if (enc_rand) begin
        if (stall == 0 && $urandom_range(0, 40) == 0) stall = 10;
        if (stall > 0) begin
          enc_if.m_meta_ready = 1'b0;
          stall--;
        end else begin
          enc_if.m_meta_ready = ($urandom_range(0, 3) != 0);
        end
        enc_if.m_pay_tready = ($urandom_range(0, 2) != 0);
      end else begin
        enc_if.m_meta_ready = 1'b1;
        enc_if.m_pay_tready = 1'b1;
      end
    end
  end

  // Requester k: issue NPKT packets, each metadata then a tlast-terminated stream.
  task automatic drive_req(input int k);
    pkt_t pk;
    int   nb, to;
    for (int p = 0; p < NPKT; p++) begin
      repeat ($urandom_range(0, 6)) begin
        @(posedge iClk);
        #1;
      end
      nb      = $urandom_range(1, 5);
      pk      = '0;
      pk.nb   = 4'(nb);
      pk.meta = {16'(nb * 4), 32'($urandom), 32'($urandom), 16'($urandom),
                 16'($urandom), 8'($urandom), 8'(k)};
      for (int b = 0; b < nb; b++)
        pk.beat[b] = {32'($urandom), 4'($urandom_range(1, 15)), (b == nb - 1),
                      1'($urandom_range(0, 1))};
      exp_q[k].push_back(pk);
      d_meta[k] = pk.meta;
      d_mv[k]   = 1'b1;
      to = 0;
      forever begin
        @(negedge iClk);
        if (req_if.s_meta_ready[k]) break;
        if (++to > 3000) begin
          chk("meta_hs_timeout", 1'b0, 1'b1);
          break;
        end
      end
      @(posedge iClk);
      #1;
      d_mv[k]   = 1'b0;
      d_meta[k] = '0;
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge iClk);
          #1;
        end
        {d_td[k], d_tk[k], d_tl[k], d_tu[k]} = pk.beat[b];
        d_tv[k] = 1'b1;
        to = 0;
        forever begin
          @(negedge iClk);
          if (req_if.s_pay_tready[k]) break;
          if (++to > 3000) begin
            chk("pay_hs_timeout", 1'b0, 1'b1);
            break;
          end
        end
        @(posedge iClk);
        #1;
        {d_td[k], d_tk[k], d_tl[k], d_tu[k], d_tv[k]} = '0;
      end
    end
  endtask

  // Monitor / reference model: 0 idle, 1 header offered, 2 payload.
  bit            mon_en = 1'b0;
  int            ph = 0, win = 0, mlast = NR - 1, bi = 0;
  logic [31:0]   cnt_m = '0;
  logic          prev_idle = 1'b1;
  logic [NR-1:0] prev_v = '0;
  pkt_t          cur;

  always @(negedge iClk) begin
    logic just_ended;
    logic exp_grant;
    int   w;
    if (mon_en) begin
      just_ended = 1'b0;
      chk("pkt_count", o_pkt_count, cnt_m);
      if (ph == 0) begin
        exp_grant = prev_idle && (prev_v != '0);
        chk("grant_latency", enc_if.m_meta_valid, exp_grant);
        w = rr_pick(mlast, prev_v);
        if (enc_if.m_meta_valid && w >= 0) begin
          win = w;
          if (exp_q[win].size() == 0) chk("sb_underflow", 1'b1, 1'b0);
          else cur = exp_q[win].pop_front();
          ph = 1;
        end
      end
      chk("busy", o_busy, (ph != 0));
      chk("grant", o_grant, (ph != 0) ? onehot(win) : '0);
      chk("s_meta_ready", req_if.s_meta_ready,
          (ph == 1) ? (onehot(win) & {NR{enc_if.m_meta_ready}}) : '0);
      chk("s_pay_tready", req_if.s_pay_tready,
          (ph == 2) ? (onehot(win) & {NR{enc_if.m_pay_tready}}) : '0);
      if (ph == 1) begin
        chk("meta_fields", {enc_if.m_meta_payload_len, enc_if.m_meta_src_ip,
            enc_if.m_meta_dst_ip, enc_if.m_meta_src_port, enc_if.m_meta_dst_port,
            enc_if.m_meta_flags, enc_if.m_meta_endpoint_id}, cur.meta);
      end
      if (ph != 2) begin
        chk("pay_idle", {enc_if.m_pay_tvalid, enc_if.m_pay_tdata, enc_if.m_pay_tkeep,
            enc_if.m_pay_tlast, enc_if.m_pay_tuser}, '0);
      end else begin
        chk("meta_valid_in_data", enc_if.m_meta_valid, 1'b0);
        chk("pay_tvalid", enc_if.m_pay_tvalid, d_tv[win]);
      end
      if (ph == 1 && enc_if.m_meta_ready) begin
        mlast = win;
        ph    = 2;
        bi    = 0;
      end else if (ph == 2 && enc_if.m_pay_tvalid && enc_if.m_pay_tready) begin
        if (bi >= int'(cur.nb)) begin
          chk("extra_beat", 1'b1, 1'b0);
        end else begin
          chk("beat", {enc_if.m_pay_tdata, enc_if.m_pay_tkeep, enc_if.m_pay_tlast,
              enc_if.m_pay_tuser}, cur.beat[bi]);
          if (bi == int'(cur.nb) - 1) begin
            cnt_m++;
            ph = 0;
            just_ended = 1'b1;
          end
          bi++;
        end
      end
      prev_idle = (ph == 0) && !just_ended;
      prev_v    = req_if.s_meta_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    for (int i = 0; i < NR; i++) begin
      d_meta[i] = '0;
      {d_mv[i], d_td[i], d_tk[i], d_tv[i], d_tl[i], d_tu[i]} = '0;
    end
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_grant", o_grant, '0);
    chk("rst_count", o_pkt_count, '0);
    chk("rst_meta", {enc_if.m_meta_valid, enc_if.m_meta_payload_len, enc_if.m_meta_src_ip,
        enc_if.m_meta_dst_ip, enc_if.m_meta_src_port, enc_if.m_meta_dst_port,
        enc_if.m_meta_flags, enc_if.m_meta_endpoint_id}, '0);
    chk("rst_pay", {enc_if.m_pay_tvalid, enc_if.m_pay_tdata, enc_if.m_pay_tkeep,
        enc_if.m_pay_tlast, enc_if.m_pay_tuser}, '0);
    chk("rst_readies", {req_if.s_meta_ready, req_if.s_pay_tready}, '0);
    @(negedge iClk);
    iRst_n = 1'b1;
    mon_en = 1'b1;

    fork
      drive_req(0);
      drive_req(1);
      drive_req(2);
      drive_req(3);
    join
    repeat (20) @(posedge iClk);
    #1;
    chk("pkt_total", o_pkt_count, 32'(NR * NPKT));
    left = 0;
    for (int i = 0; i < NR; i++) left += exp_q[i].size();
    chk("sb_empty", 32'(left), 32'd0);

    // Reset mid-packet, then a fresh arbitration from reset priority.
    mon_en   = 1'b0;
    enc_rand = 1'b0;
    @(posedge iClk);
    #2;
    d_meta[0] = {$urandom, $urandom, $urandom, $urandom};
    d_meta[2] = {16'd16, $urandom, $urandom, $urandom, 16'h0002};
    d_mv[2]   = 1'b1;
    {d_td[2], d_tk[2], d_tv[2], d_tl[2], d_tu[2]} = {32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0};
    repeat (5) @(posedge iClk);
    #2;
    chk("pre_rst_grant", {o_busy, o_grant}, {1'b1, 4'b0100});
    chk("pre_rst_pay", {enc_if.m_pay_tvalid, enc_if.m_pay_tdata}, {1'b1, 32'hDEADBEEF});
    iRst_n = 1'b0;
    #1;
    chk("async_rst_state", {o_busy, o_grant, o_pkt_count}, '0);
    chk("async_rst_hs", {enc_if.m_meta_valid, enc_if.m_pay_tvalid,
        req_if.s_meta_ready, req_if.s_pay_tready}, '0);
    d_mv[2] = 1'b0;
    {d_td[2], d_tk[2], d_tv[2], d_tl[2], d_tu[2]} = '0;
    d_mv[0] = 1'b1;
    d_mv[3] = 1'b1;
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
    chk("post_rst_grant", {enc_if.m_meta_valid, o_grant}, {1'b1, 4'b0001});
    chk("post_rst_meta", {enc_if.m_meta_payload_len, enc_if.m_meta_src_ip,
        enc_if.m_meta_dst_ip, enc_if.m_meta_src_port, enc_if.m_meta_dst_port,
        enc_if.m_meta_flags, enc_if.m_meta_endpoint_id}, d_meta[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
